rv32i_instr_encoder: RTL and testbench
======================================

// Module: rv32i_instr_encoder
// PURPOSE
//  Inverse of the datapath immediate generator: packs opcode, register fields and a
//  32-bit signed immediate into one RV32I instruction word.
//  Immediate bits are scattered per format (I/S/B/J, optional CSR-imm).
//  Feeds the boot-ROM/self-test instruction stream and the ISS cross-check bench.
//  Valid/ready in, 1-stage check/pack register, DEPTH-entry output FIFO,
//  range/alignment checking with a saturating error counter.
// PARAMETERS
//  DEPTH   4   output FIFO entries; power of 2, >=2
//  CNT_W   16  width of err_cnt
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid&in_ready at clk edge
//  in_op      in   7      opcode
//  in_rd      in   5      rd field
//  in_rs1     in   5      rs1 field
//  in_rs2     in   5      rs2 field (CSR: csr[4:0])
//  in_funct3  in   3      funct3
//  in_funct7  in   7      funct7 (CSR: csr[11:5])
//  in_imm     in   32     signed immediate (CSR: zimm, unsigned)
//  out_valid  out  1      out_instr/out_err valid
//  out_ready  in   1      consumer accepts when out_valid&out_ready
//  out_instr  out  32     encoded word
//  out_err    out  1      request rejected; out_instr = NOP 32'h0000_0013
//  err_cnt    out  CNT_W  rejected-request count, saturating
//  busy       out  1      stage reg or FIFO non-empty
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_instr=0, out_err=0, err_cnt=0, busy=0.
//  Reset mid-operation drops stage reg and all FIFO contents.
//  Formats by in_op:
//   3, 19 -> I: {imm[11:0],rs1,f3,rd,op}; range -2048..2047
//   35    -> S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}; range -2048..2047
//   99    -> B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op};
//            range -4096..4094, imm[0]=0
//   111   -> J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op};
//            range -2^20..2^20-2, imm[0]=0
//   51    -> R: {f7,rs2,rs1,f3,rd,op}; imm ignored
//   other -> error
//  Error (out of range, misaligned, unsupported op): emit NOP with out_err=1.
//   err_cnt+1, holds at all-ones. Unused fields per format are ignored.
//  Stage reg loads on accept; moves to FIFO when FIFO not full.
//   in_ready = !s1_valid | !fifo_full, from registered state only;
//   no same-cycle pop-through. Total buffering DEPTH+1.
//  Latency: accepted at edge E0 -> FIFO at E1 -> out_valid after E1
//   (2 cycles, empty FIFO, no bypass).
//  FIFO: show-ahead, pointers wrap mod DEPTH.
//   Simultaneous push+pop keeps count; order strictly preserved.
//  out_instr/out_err stay stable while out_valid & !out_ready.
// CONFIGURATION
//  ENC_CSR_EN defined:
//   in_op=115 -> {f7,rs2,imm[4:0],f3,rd,op}; requires 0<=imm<=31 and f3 in {5,6,7}.
//  ENC_CSR_EN undefined: 115 is unsupported -> NOP + err.
// STRUCTURE
//  Shared header package rv32i_enc_defs.vh:
//   opcode localparams OP_LOAD/OP_IMM/OP_STORE/OP_BRANCH/OP_JAL/OP_SYSTEM/OP_R,
//   NOP_INSTR, per-format min/max immediate bounds.
//  Sub-module enc_fifo (DEPTH, WIDTH=33): sync FIFO with full/empty flags.
// TESTING
//  op=19,rd=1,rs1=2,f3=0,imm=-1 -> 32'hFFF10093, err=0,
//   out_valid 2 cycles after accept.
//  op=35,rs1=10,rs2=5,f3=2,imm=8 -> 32'h00552423.
//  op=111,rd=1,imm=-4 -> 32'hFFDFF0EF;
//   op=99,imm=3 -> 32'h00000013, err=1, err_cnt=1.
//  op=115,f3=5,rd=0,imm=5,{f7,rs2}=12'h300 -> 32'h3002D073 with ENC_CSR_EN;
//   NOP+err without it.
//  out_ready=0, DEPTH+2 requests -> in_ready low after DEPTH+1 accepts;
//   release -> all words in order, none lost.
//  rst=1 for 1 cycle with 3 words queued -> out_valid=0, err_cnt=0, busy=0 next cycle.

Source files
------------

// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared opcodes, immediate bounds and the word format for the RV32I instruction encoder.
// ENC_CSR_EN enables the CSR-immediate (SYSTEM) format; without it opcode 115 is rejected.
package rv32i_instr_encoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_SYSTEM = 7'd115;
  localparam logic [6:0] OP_R      = 7'd51;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int signed I_IMM_MIN = -2048;
  localparam int signed I_IMM_MAX = 2047;
  localparam int signed S_IMM_MIN = -2048;
  localparam int signed S_IMM_MAX = 2047;
  localparam int signed B_IMM_MIN = -4096;
  localparam int signed B_IMM_MAX = 4094;
  localparam int signed J_IMM_MIN = -1048576;
  localparam int signed J_IMM_MAX = 1048574;
  localparam logic [31:0] CSR_ZIMM_MAX = 32'd31;

  localparam int ENC_W = 33;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_R,
    FMT_CSR,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } enc_word_t;

  function automatic fmt_e op_to_fmt(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM: return FMT_I;
      OP_STORE:        return FMT_S;
      OP_BRANCH:       return FMT_B;
      OP_JAL:          return FMT_J;
      OP_R:            return FMT_R;
`ifdef ENC_CSR_EN
      OP_SYSTEM:       return FMT_CSR;
`endif
      default:         return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// Request and result handshake bundle of the RV32I instruction encoder.
interface rv32i_instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready,
    output out_valid, out_instr, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready,
    input  out_valid, out_instr, out_err,
    output out_ready
  );

endinterface

// File: rtl/rv32i_instr_encoder_enc_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags; DEPTH must be a power of two.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty flag gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Packs opcode, register fields and a signed immediate into one RV32I word, with a check
// stage, output FIFO and saturating reject counter. ENC_CSR_EN adds the CSR-immediate format.
module rv32i_instr_encoder
  import rv32i_instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32i_instr_encoder_if.slave  bus,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

  fmt_e               fmt;
  logic [31:0]        imm;
  logic signed [31:0] imm_s;
  logic [31:0]        raw_instr;
  logic               enc_err;
  enc_word_t          enc_word;

  logic               s1_valid_q, s1_valid_d;
  enc_word_t          s1_word_q, s1_word_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               accept;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENC_W-1:0]   fifo_rdata;
  enc_word_t          fifo_word;

  assign fmt   = op_to_fmt(bus.in_op);
  assign imm   = bus.in_imm;
  assign imm_s = $signed(bus.in_imm);

  always_comb begin
    raw_instr = NOP_INSTR;
    enc_err   = 1'b0;
    case (fmt)
      FMT_I: begin
        raw_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_op};
        enc_err   = (imm_s < I_IMM_MIN) || (imm_s > I_IMM_MAX);
      end
      FMT_S: begin
        raw_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_op};
        enc_err   = (imm_s < S_IMM_MIN) || (imm_s > S_IMM_MAX);
      end
      FMT_B: begin
        raw_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     imm[4:1], imm[11], bus.in_op};
        enc_err   = (imm_s < B_IMM_MIN) || (imm_s > B_IMM_MAX) || imm[0];
      end
      FMT_J: begin
        raw_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_op};
        enc_err   = (imm_s < J_IMM_MIN) || (imm_s > J_IMM_MAX) || imm[0];
      end
      FMT_R: begin
        raw_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_op};
      end
      // Only the immediate CSR forms (funct3 5..7) carry a zimm in the rs1 slot.
      FMT_CSR: begin
        raw_instr = {bus.in_funct7, bus.in_rs2, imm[4:0], bus.in_funct3, bus.in_rd, bus.in_op};
        enc_err   = (imm > CSR_ZIMM_MAX) || (bus.in_funct3 < 3'd5);
      end
      default: enc_err = 1'b1;
    endcase
    enc_word.err   = enc_err;
    enc_word.instr = enc_err ? NOP_INSTR : raw_instr;
  end

  // Ready depends only on registered occupancy, so a pop never frees a slot the same cycle.
  assign bus.in_ready = ~s1_valid_q | ~fifo_full;
  assign accept       = bus.in_valid & bus.in_ready;
  assign fifo_push    = s1_valid_q & ~fifo_full;
  assign fifo_pop     = bus.out_ready & ~fifo_empty;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    err_cnt_d  = err_cnt_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_word_d  = enc_word;
    end else if (fifo_push) begin
      s1_valid_d = 1'b0;
    end
    if (accept && enc_word.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_word_q  <= s1_word_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (s1_word_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_word     = enc_word_t'(fifo_rdata);
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_instr = fifo_empty ? 32'h0 : fifo_word.instr;
  assign bus.out_err   = ~fifo_empty & fifo_word.err;
  assign err_cnt       = err_cnt_q;
  assign busy          = s1_valid_q | ~fifo_empty;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Randomized self-checking bench for rv32i_instr_encoder against a scoreboard and a
// field-arithmetic reference encoder; honours ENC_CSR_EN the same way as the design.
module tb_rv32i_instr_encoder;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  rv32i_instr_encoder_if bus();

  rv32i_instr_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          model_err = 0;
  bit          dir_mode = 1'b0;
  logic [32:0] dir_exp = '0;
  bit          accepted = 1'b0;
  bit          hold_v = 1'b0;
  logic [32:0] hold_word = '0;
  int          op_tbl[7] = '{3, 19, 35, 99, 111, 51, 115};
  int          bnd_tbl[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4097,
                               -1048576, 1048574, 1048576, -1048577};

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference encoder: pulls immediate bits out with shifts and masks and range-checks as integers.
  function automatic logic [32:0] refEncode(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
    int          v;
    int unsigned u;
    int unsigned w;
    int          opi;
    bit          bad;
    v   = imm;
    u   = imm;
    opi = int'(op);
    w   = 0;
    bad = 1'b0;
    if (opi == 3 || opi == 19) begin
      bad = (v < -2048) || (v > 2047);
      w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
    end else if (opi == 35) begin
      bad = (v < -2048) || (v > 2047);
      w = (((u >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
        | ((u & 32'h1f) << 7) | 32'(op);
    end else if (opi == 99) begin
      bad = (v < -4096) || (v > 4094) || ((u & 1) != 0);
      w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (32'(rs2) << 20)
        | (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hf) << 8)
        | (((u >> 11) & 1) << 7) | 32'(op);
    end else if (opi == 111) begin
      bad = (v < -1048576) || (v > 1048574) || ((u & 1) != 0);
      w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20)
        | (((u >> 12) & 32'hff) << 12) | (32'(rd) << 7) | 32'(op);
    end else if (opi == 51) begin
      w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
        | (32'(rd) << 7) | 32'(op);
    end else if (opi == 115) begin
`ifdef ENC_CSR_EN
      bad = (u > 31) || (f3 < 3'd5);
      w = (32'(f7) << 25) | (32'(rs2) << 20) | ((u & 32'h1f) << 15) | (32'(f3) << 12)
        | (32'(rd) << 7) | 32'(op);
`else
      bad = 1'b1;
`endif
    end else begin
      bad = 1'b1;
    end
    if (bad) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  // One clock: sample both handshakes on the falling edge, then check state after the rise.
  task automatic stepCycle();
    logic [32:0] obs;
    logic [32:0] exp;
    logic [32:0] nw;
    @(negedge clk);
    accepted = 1'b0;
    obs = {bus.out_err, bus.out_instr};
    if (hold_v && bus.out_valid) checkOutput("hold_stable", 64'(obs), 64'(hold_word));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out", 64'(bus.out_valid), 64'(0));
      end else begin
        exp = exp_q.pop_front();
        checkOutput("out_word", 64'(obs), 64'(exp));
      end
    end
    hold_v    = bus.out_valid && !bus.out_ready;
    hold_word = obs;
    if (bus.in_valid && bus.in_ready) begin
      nw = dir_mode ? dir_exp
                    : refEncode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2,
                                bus.in_funct3, bus.in_funct7, bus.in_imm);
      exp_q.push_back(nw);
      if (nw[32] && model_err < ERR_MAX) model_err++;
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput("err_cnt", 64'(err_cnt), 64'(model_err));
    checkOutput("busy", 64'(busy), 64'(exp_q.size() != 0));
    checkOutput("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < DEPTH + 1));
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm, input bit use_exp, input logic [32:0] expw);
    int n;
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
    dir_mode      = use_exp;
    dir_exp       = expw;
    accepted      = 1'b0;
    n             = 0;
    while (!accepted && n < 50) begin
      stepCycle();
      n++;
    end
    if (!accepted) checkOutput("accept_timeout", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b0;
    dir_mode     = 1'b0;
  endtask

  task automatic randomizeReq();
    int sel;
    sel = $urandom_range(0, 7);
    bus.in_op     = (sel < 7) ? 7'(op_tbl[sel]) : 7'($urandom);
    bus.in_rd     = 5'($urandom);
    bus.in_rs1    = 5'($urandom);
    bus.in_rs2    = 5'($urandom);
    bus.in_funct3 = 3'($urandom);
    bus.in_funct7 = 7'($urandom);
    case ($urandom_range(0, 4))
      0:       bus.in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       bus.in_imm = $urandom;
      2:       bus.in_imm = 32'($urandom_range(0, 40));
      3:       bus.in_imm = 32'(bnd_tbl[$urandom_range(0, 11)]);
      default: bus.in_imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'(0));
    checkOutput("drain_out_valid", 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_out_instr", 64'(bus.out_instr), 64'(0));
    checkOutput("rst_out_err", 64'(bus.out_err), 64'(0));
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));

    $display("[TB] directed vectors");
    applyStimulus(7'd19, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'hFFF10093});
    checkOutput("lat_e0_out_valid", 64'(bus.out_valid), 64'(0));
    stepCycle();
    checkOutput("lat_e1_out_valid", 64'(bus.out_valid), 64'(1));
    drain();
    applyStimulus(7'd35, 5'd0, 5'd10, 5'd5, 3'd2, 7'd0, 32'd8, 1'b1, {1'b0, 32'h00552423});
    applyStimulus(7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1'b1, {1'b0, 32'hFFDFF0EF});
    applyStimulus(7'd99, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1, {1'b1, 32'h00000013});
    drain();
    checkOutput("err_cnt_after_b", 64'(err_cnt), 64'(1));
`ifdef ENC_CSR_EN
    applyStimulus(7'd115, 5'd0, 5'd0, 5'd0, 3'd5, 7'h18, 32'd5, 1'b1, {1'b0, 32'h3002D073});
`else
    applyStimulus(7'd115, 5'd0, 5'd0, 5'd0, 3'd5, 7'h18, 32'd5, 1'b1, {1'b1, 32'h00000013});
`endif
    drain();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      randomizeReq();
      bus.in_valid = 1'b1;
      stepCycle();
      if (accepted) acc++;
    end
    bus.in_valid = 1'b0;
    checkOutput("bp_accepts", 64'(acc), 64'(DEPTH + 1));
    checkOutput("bp_in_ready", 64'(bus.in_ready), 64'(0));
    drain();

    $display("[TB] reset with words queued");
    bus.out_ready = 1'b0;
    applyStimulus(7'd19, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0, 32'd100, 1'b0, '0);
    applyStimulus(7'd0, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0, 32'd100, 1'b0, '0);
    applyStimulus(7'd51, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0, 1'b0, '0);
    repeat (2) stepCycle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_err = 0;
    hold_v    = 1'b0;
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("mid_rst_err_cnt", 64'(err_cnt), 64'(0));
    checkOutput("mid_rst_busy", 64'(busy), 64'(0));
    checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("mid_rst_out_instr", 64'(bus.out_instr), 64'(0));
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      randomizeReq();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      stepCycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
